// File: rtl/pulse_gen_pkg.sv
// Shared mode encodings, default step periods and run-state type for the
// fitness-tracker step-pulse generator.
package pulse_gen_pkg;

    localparam logic [1:0] MODE_WALK = 2'b00;
    localparam logic [1:0] MODE_JOG  = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    localparam int PERIOD_WALK_DEF = 1000;
    localparam int PERIOD_JOG_DEF  = 500;
    localparam int PERIOD_RUN_DEF  = 250;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/pulse_period_sel.sv
// Combinational activity-mode to pulse-period lookup; valid is low for the
// idle mode code so the top can park its counter.
module pulse_period_sel
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PERIOD_WALK = PERIOD_WALK_DEF,
    parameter int PERIOD_JOG  = PERIOD_JOG_DEF,
    parameter int PERIOD_RUN  = PERIOD_RUN_DEF
) (
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] period,
    output logic             valid
);

    always_comb begin
        period = '0;
        valid  = 1'b0;
        case (mode)
            MODE_WALK: begin
                period = CNT_W'(PERIOD_WALK);
                valid  = 1'b1;
            end
            MODE_JOG: begin
                period = CNT_W'(PERIOD_JOG);
                valid  = 1'b1;
            end
            MODE_RUN: begin
                period = CNT_W'(PERIOD_RUN);
                valid  = 1'b1;
            end
            MODE_IDLE: begin
                period = '0;
                valid  = 1'b0;
            end
            default: begin
                period = '0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pulse_generator.sv
// Step-pulse source: single-cycle registered pulses every P cycles while running.
// Define PULSE_GEN_STEP_COUNT_EN to add the saturating 16-bit step_count output.
module pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int PERIOD_WALK = PERIOD_WALK_DEF,
    parameter int PERIOD_JOG  = PERIOD_JOG_DEF,
    parameter int PERIOD_RUN  = PERIOD_RUN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       MODE,
    input  logic             START,
    input  logic             STOP,
    output logic             pulse_out,
    output run_state_t       state,
    output logic [CNT_W-1:0] cnt
`ifdef PULSE_GEN_STEP_COUNT_EN
    ,
    output logic [15:0]      step_count
`endif
);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [CNT_W-1:0] last_cnt;
`ifdef PULSE_GEN_STEP_COUNT_EN
    logic [15:0]      step_q, step_d;
`endif

    pulse_period_sel #(
        .CNT_W       (CNT_W),
        .PERIOD_WALK (PERIOD_WALK),
        .PERIOD_JOG  (PERIOD_JOG),
        .PERIOD_RUN  (PERIOD_RUN)
    ) u_period_sel (
        .mode   (MODE),
        .period (period),
        .valid  (period_valid)
    );

    assign last_cnt = period - CNT_W'(1);

    // >= rather than == so a switch to a shorter period fires on the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef PULSE_GEN_STEP_COUNT_EN
        step_d  = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (START && !STOP) begin
                    state_d = ST_RUN;
`ifdef PULSE_GEN_STEP_COUNT_EN
                    step_d  = '0;
`endif
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!period_valid) begin
                    cnt_d = '0;
                end else if (cnt_q >= last_cnt) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
`ifdef PULSE_GEN_STEP_COUNT_EN
                    if (step_q != 16'hFFFF) step_d = step_q + 16'd1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
`ifdef PULSE_GEN_STEP_COUNT_EN
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
`ifdef PULSE_GEN_STEP_COUNT_EN
            step_q  <= step_d;
`endif
        end
    end

    assign pulse_out = pulse_q;
    assign state     = state_q;
    assign cnt       = cnt_q;
`ifdef PULSE_GEN_STEP_COUNT_EN
    assign step_count = step_q;
`endif

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: pulse positions are predicted from the
// START/MODE/STOP edges and compared against recorded pulse edge numbers.
module tb_pulse_generator;
    import pulse_gen_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       MODE = MODE_WALK;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             pulse_out;
    run_state_t       state;
    logic [CNT_W-1:0] cnt;
`ifdef PULSE_GEN_STEP_COUNT_EN
    logic [15:0]      step_count;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_edge = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    pulse_generator dut (
        .clk       (clk),
        .reset     (reset),
        .MODE      (MODE),
        .START     (START),
        .STOP      (STOP),
        .pulse_out (pulse_out),
        .state     (state),
        .cnt       (cnt)
`ifdef PULSE_GEN_STEP_COUNT_EN
        ,
        .step_count(step_count)
`endif
    );

    // clock/reset block; cyc equals the number of the most recent rising edge
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record the edge number that launched each pulse cycle
    always @(posedge clk) begin
        #2;
        if (pulse_out === 1'b1) obs_q.push_back(32'(cyc));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b need 0", pulse_out); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d need 0", cnt); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d need %0d", state, ST_IDLE); end
`ifdef PULSE_GEN_STEP_COUNT_EN
        total++; if (step_count !== 16'd0) begin bad++; $display("FAIL reset_steps: got %0d need 0", step_count); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_walk;
        int k;
        @(negedge clk);
        obs_q.delete(); exp_q.delete();
        MODE = MODE_WALK; START = 1'b1; k = cyc + 1;
        @(negedge clk);
        START = 1'b0;
        for (int i = 1; i <= 11; i++) exp_q.push_back(32'(k + 1000 * i));
        wait_cyc(k + 1500);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        wait_cyc(k + 11000);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL walk_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL walk_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
`ifdef PULSE_GEN_STEP_COUNT_EN
        total++; if (step_count !== 16'd11) begin bad++; $display("FAIL walk_steps: got %0d need 11", step_count); end
`endif
        last_edge = k + 11000;
    endtask

    task automatic test_mode_change;
        int l;
        l = last_edge;
        obs_q.delete(); exp_q.delete();
        wait_cyc(l + 100);
        MODE = MODE_JOG;
        for (int i = 1; i <= 20; i++) exp_q.push_back(32'(l + 500 * i));
        wait_cyc(l + 10000);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL jog_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL jog_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
        l = l + 10000;
        obs_q.delete(); exp_q.delete();
        wait_cyc(l + 50);
        MODE = MODE_RUN;
        for (int i = 1; i <= 40; i++) exp_q.push_back(32'(l + 250 * i));
        wait_cyc(l + 10000);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL run_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL run_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
        last_edge = l + 10000;
    endtask

    task automatic test_switch_overrun;
        int l;
        l = last_edge;
        obs_q.delete(); exp_q.delete();
        wait_cyc(l + 50);
        MODE = MODE_WALK;
        wait_cyc(l + 600);
        total++; if (cnt !== CNT_W'(600)) begin bad++; $display("FAIL switch_cnt: got %0d need 600", cnt); end
        MODE = MODE_RUN;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(l + 601 + 250 * i));
        wait_cyc(l + 1601);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL switch_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL switch_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
        last_edge = l + 1601;
    endtask

    task automatic test_stop;
        int t0;
        int k;
        obs_q.delete(); exp_q.delete();
        wait_cyc(last_edge + 30);
        STOP = 1'b1;
        @(negedge clk);
        STOP = 1'b0;
        total++; if (cnt !== '0) begin bad++; $display("FAIL stop_cnt: got %0d need 0", cnt); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL stop_state: got %0d need %0d", state, ST_IDLE); end
        t0 = cyc;
        wait_cyc(t0 + 2000);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL stop_quiet: got %0d pulses need 0", obs_q.size()); end
        // restart, then stop exactly on a terminal-count edge
        obs_q.delete();
        MODE = MODE_RUN; START = 1'b1; k = cyc + 1;
        @(negedge clk);
        START = 1'b0;
        exp_q.push_back(32'(k + 250));
        wait_cyc(k + 499);
        STOP = 1'b1;
        @(negedge clk);
        STOP = 1'b0;
        wait_cyc(k + 1500);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL stop_tc_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stop_tc_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_start_stop_same;
        int t0;
        obs_q.delete();
        @(negedge clk);
        START = 1'b1; STOP = 1'b1;
        @(negedge clk);
        START = 1'b0; STOP = 1'b0;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL both_state: got %0d need %0d", state, ST_IDLE); end
        t0 = cyc;
        wait_cyc(t0 + 1000);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL both_quiet: got %0d pulses need 0", obs_q.size()); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL both_cnt: got %0d need 0", cnt); end
    endtask

    task automatic test_idle_mode;
        int k;
        int c;
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        MODE = MODE_RUN; START = 1'b1; k = cyc + 1;
        @(negedge clk);
        START = 1'b0;
        wait_cyc(k + 300);
        MODE = MODE_IDLE;
        wait_cyc(k + 310);
        total++; if (cnt !== '0) begin bad++; $display("FAIL idle_cnt: got %0d need 0", cnt); end
        total++; if (state !== ST_RUN) begin bad++; $display("FAIL idle_state: got %0d need %0d", state, ST_RUN); end
        wait_cyc(k + 2000);
        c = cyc;
        MODE = MODE_RUN;
        exp_q.push_back(32'(k + 250));
        exp_q.push_back(32'(c + 250));
        exp_q.push_back(32'(c + 500));
        wait_cyc(c + 500);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL idle_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL idle_edge[%0d]: got %0d need %0d", i, obs_q[i], exp_q[i]); end
        end
        last_edge = c + 500;
    endtask

    task automatic test_async_reset;
        int t0;
        wait_cyc(last_edge + 250);
        total++; if (pulse_out !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b need 1", pulse_out); end
        #1 reset = 1'b1;
        #1;
        total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL areset_pulse: got %b need 0", pulse_out); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL areset_cnt: got %0d need 0", cnt); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL areset_state: got %0d need %0d", state, ST_IDLE); end
`ifdef PULSE_GEN_STEP_COUNT_EN
        total++; if (step_count !== 16'd0) begin bad++; $display("FAIL areset_steps: got %0d need 0", step_count); end
`endif
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        t0 = cyc;
        wait_cyc(t0 + 600);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL areset_quiet: got %0d pulses need 0", obs_q.size()); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL areset_idle: got %0d need %0d", state, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_mode_change();
        test_switch_overrun();
        test_stop();
        test_start_stop_same();
        test_idle_mode();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Programmable-rate step-pulse source for the fitness-tracker datapath. It emits single-cycle pulses at one of three activity rates (walk, jog, run) selected by `MODE`, gated by `START`/`STOP` controls. Downstream step counters and calorie logic consume `pulse_out`.

## Interface
- `PERIOD_WALK`, default 1000: cycles between pulses, MODE=00.
- `PERIOD_JOG`, default 500: cycles between pulses, MODE=01.
- `PERIOD_RUN`, default 250: cycles between pulses, MODE=10.
- `CNT_W`, default 16: period counter width; every period must be ≥2 and < 2^CNT_W.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MODE`  in  2  rate select: 00 walk, 01 jog, 10 run, 11 idle.
- `START`  in  1  synchronous run request, level-sampled each cycle.
- `STOP`  in  1  synchronous halt request, level-sampled each cycle.
- `pulse_out`  out  1  one-cycle-high step pulse, registered.

## Operation
- Internal `running` flag and counter `cnt` (CNT_W bits).
- `reset` asserted: `running`=0, `cnt`=0, `pulse_out`=0, immediately.
- STOP=1 on an edge: `running`←0, `cnt`←0. STOP has priority over START in the same cycle.
- START=1 while idle: `running`←1, `cnt`←0. START while running is ignored; the count is not restarted.
- While running, with P = period of the current MODE:
  - if `cnt` ≥ P−1: `pulse_out`←1, `cnt`←0;
  - otherwise `cnt`←`cnt`+1 and `pulse_out`←0.
- MODE=11 while running: no pulses, `cnt` held at 0, `running` stays 1. Pulsing resumes when MODE returns to a valid code.
- MODE change mid-run takes effect on the next edge. No restart. The `≥` compare guarantees a pulse on the next edge if `cnt` already exceeds the new P−1.
- Not running: `pulse_out`=0 and `cnt` frozen at 0.

## Timing
- START sampled at edge k: first pulse is high during the cycle after edge k+P. Pulse period is exactly P cycles thereafter.
- `pulse_out` is always exactly one cycle wide, never back-to-back, since P ≥ 2.
- STOP sampled at edge k: `pulse_out` is 0 from edge k on, including when it coincides with a terminal count.
- `reset` deasserting mid-run returns the block to idle; it needs a new START.
- No combinational path from inputs to `pulse_out`.

## Configuration
- `PULSE_GEN_STEP_COUNT_EN` defined: adds output `step_count` (16 bits). It resets to 0, increments on each `pulse_out`, saturates at 16'hFFFF, and is cleared by START from idle. It is not cleared by STOP.
- Not defined: the port and its logic are absent. `pulse_out` behaviour is identical either way.

## Structure
- Shared package `pulse_gen_pkg` holds:
  - mode encodings `MODE_WALK`=2'b00, `MODE_JOG`=2'b01, `MODE_RUN`=2'b10, `MODE_IDLE`=2'b11;
  - default period constants.
- Sub-module `pulse_period_sel`: combinational MODE→P lookup, with a valid flag that is low for MODE_IDLE.
- Top holds the run flag, counter and output register.

## Test plan
- Reset held for 20 ns, then START pulse at 30–40 ns with MODE=00 → first `pulse_out` 1000 cycles after the START edge; 10 pulses in the next 10000 cycles, each 1 cycle wide.
- MODE 00→01 mid-run, then 01→10 after 10000 cycles → spacing becomes 500, then 250 cycles. 20 and 40 pulses per 10000-cycle window respectively. No pulse wider than 1 cycle.
- Switch 00→10 when `cnt`=600 → pulse on the next edge, then 250-cycle spacing.
- STOP pulse in run mode → no further pulses. `cnt` reads 0. A later START restarts with a full P-cycle delay.
- START and STOP asserted in the same cycle from idle → stays idle, no pulses. MODE=11 while running → no pulses until MODE=10, then first pulse 250 cycles later.
- Async `reset` asserted mid-cycle while running → `pulse_out` drops to 0 before the next clock edge. With `PULSE_GEN_STEP_COUNT_EN`, `step_count`=0.
